// File: rtl/cpm_disk_pkg.sv
// Shared constants for the CP/M disk controller: register map, command codes,
// status bit positions and the controller FSM state encoding.
package cpm_disk_pkg;

   localparam int LBA_W = 26;

   localparam logic [2:0] REG_DRIVE  = 3'd0;
   localparam logic [2:0] REG_TRK_LO = 3'd1;
   localparam logic [2:0] REG_TRK_HI = 3'd2;
   localparam logic [2:0] REG_SECTOR = 3'd3;
   localparam logic [2:0] REG_DMA_LO = 3'd4;
   localparam logic [2:0] REG_DMA_HI = 3'd5;
   localparam logic [2:0] REG_CMD    = 3'd6;
   localparam logic [2:0] REG_STATUS = 3'd7;

   localparam logic [7:0] CMD_READ  = 8'h00;
   localparam logic [7:0] CMD_WRITE = 8'h01;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_PARAM   = 1;
   localparam int STAT_SDERR   = 2;
   localparam int STAT_TIMEOUT = 3;
   localparam int STAT_READY   = 4;
   localparam int STAT_OVERRUN = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_BUSY,
      S_RELEASE
   } state_t;

endpackage

// File: rtl/cpm_lba_calc.sv
// Two-stage pipelined CP/M (drive, track, sector) to linear block address
// translation with range checking of all three coordinates.
module cpm_lba_calc
   import cpm_disk_pkg::*;
#(
   parameter int NUM_DRIVES  = 4,
   parameter int TRACKS      = 77,
   parameter int SPT         = 26,
   parameter int SECTOR_BASE = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       drive,
   input  logic [15:0]      track,
   input  logic [7:0]       sector,
   output logic [LBA_W-1:0] lba,
   output logic             invalid,
   output logic             vld
);

   logic [31:0]      drive_off_p0;
   logic [31:0]      track_off_p0;
   logic             invalid_p0;
   logic             vld_p0;
   logic [LBA_W-1:0] lba_p1;
   logic             invalid_p1;
   logic             vld_p1;

   // stage p0: partial products and range check; stage p1: final sum
   always_ff @(posedge clk) begin
      drive_off_p0 <= 32'(drive) * 32'(TRACKS * SPT);
      track_off_p0 <= 32'(track) * 32'(SPT) + 32'(sector) - 32'(SECTOR_BASE);
      invalid_p0   <= (32'(drive) >= 32'(NUM_DRIVES)) ||
                      (32'(track) >= 32'(TRACKS)) ||
                      (32'(sector) < 32'(SECTOR_BASE)) ||
                      (32'(sector) >= 32'(SECTOR_BASE + SPT));
      lba_p1       <= LBA_W'(drive_off_p0 + track_off_p0);
      invalid_p1   <= invalid_p0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= start;
         vld_p1 <= vld_p0;
      end
   end

   assign lba     = lba_p1;
   assign invalid = invalid_p1;
   assign vld     = vld_p1;

endmodule

// File: rtl/cpm_disk_ctrl.sv
// CP/M disk port controller: CPU register file, LBA translation and a
// handshake FSM to the SD disk emulator. Define DISK_TIMEOUT_EN for a busy timeout.
module cpm_disk_ctrl
   import cpm_disk_pkg::*;
#(
   parameter int NUM_DRIVES  = 4,
   parameter int TRACKS      = 77,
   parameter int SPT         = 26,
   parameter int SECTOR_BASE = 1,
   parameter int TIMEOUT_CYC = 27_000_000
)(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_io_wr,
   input  logic [2:0]  i_io_addr,
   input  logic [7:0]  i_io_data,
   output logic [7:0]  o_io_data,
   output logic        o_disk_read,
   output logic        o_disk_write,
   input  logic        i_disk_ready,
   input  logic [3:0]  i_sd_error,
   output logic [23:0] o_disk_block_address,
   output logic [1:0]  o_disk_block_sub_address,
   output logic [15:0] o_dma_start_address,
   output logic        o_busy
);

   state_t           state;
   logic [7:0]       drive, trk_lo, trk_hi, sector, dma_lo, dma_hi, cmd;
   logic             param_err, sd_err, overrun, timeout_flag;
   logic             calc_start;
   logic [LBA_W-1:0] lba;
   logic             lba_invalid, lba_vld;
   logic [7:0]       status;

`ifdef DISK_TIMEOUT_EN
   logic [31:0]      tcnt;
`else
   assign timeout_flag = 1'b0 && (TIMEOUT_CYC > 0);
`endif

   assign calc_start = (state == S_IDLE) && i_io_wr && (i_io_addr == REG_CMD);
   assign o_busy     = (state != S_IDLE);

   cpm_lba_calc #(
      .NUM_DRIVES  (NUM_DRIVES),
      .TRACKS      (TRACKS),
      .SPT         (SPT),
      .SECTOR_BASE (SECTOR_BASE)
   ) u_lba (
      .clk     (i_clk),
      .rst_n   (i_reset_n),
      .start   (calc_start),
      .drive   (drive),
      .track   ({trk_hi, trk_lo}),
      .sector  (sector),
      .lba     (lba),
      .invalid (lba_invalid),
      .vld     (lba_vld)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state                    <= S_IDLE;
         drive                    <= 8'h00;
         trk_lo                   <= 8'h00;
         trk_hi                   <= 8'h00;
         sector                   <= 8'h00;
         dma_lo                   <= 8'h00;
         dma_hi                   <= 8'h00;
         cmd                      <= 8'h00;
         param_err                <= 1'b0;
         sd_err                   <= 1'b0;
         overrun                  <= 1'b0;
         o_disk_read              <= 1'b0;
         o_disk_write             <= 1'b0;
         o_disk_block_address     <= 24'h0;
         o_disk_block_sub_address <= 2'b00;
         o_dma_start_address      <= 16'h0;
`ifdef DISK_TIMEOUT_EN
         timeout_flag             <= 1'b0;
         tcnt                     <= 32'd0;
`endif
      end else begin
         if (i_io_wr && (state != S_IDLE))
            overrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (i_io_wr) begin
                  case (i_io_addr)
                     REG_DRIVE:  drive  <= i_io_data;
                     REG_TRK_LO: trk_lo <= i_io_data;
                     REG_TRK_HI: trk_hi <= i_io_data;
                     REG_SECTOR: sector <= i_io_data;
                     REG_DMA_LO: dma_lo <= i_io_data;
                     REG_DMA_HI: dma_hi <= i_io_data;
                     REG_CMD: begin
                        cmd       <= i_io_data;
                        param_err <= 1'b0;
                        sd_err    <= 1'b0;
                        overrun   <= 1'b0;
`ifdef DISK_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                        state     <= S_CALC;
                     end
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               if (lba_vld) begin
                  if (lba_invalid) begin
                     param_err <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     o_disk_block_address     <= lba[LBA_W-1:2];
                     o_disk_block_sub_address <= lba[1:0];
                     o_dma_start_address      <= {dma_hi, dma_lo};
                     state                    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // request is raised on an idle emulator and held until it goes busy
               if (!(o_disk_read || o_disk_write)) begin
                  if (i_disk_ready) begin
                     o_disk_read  <= (cmd != CMD_WRITE);
                     o_disk_write <= (cmd == CMD_WRITE);
                  end
               end else if (!i_disk_ready) begin
                  o_disk_read  <= 1'b0;
                  o_disk_write <= 1'b0;
                  state        <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (i_disk_ready)
                  state <= S_RELEASE;
            end
            S_RELEASE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase

`ifdef DISK_TIMEOUT_EN
         if ((state == S_ISSUE) || (state == S_BUSY)) begin
            if (tcnt == 32'(TIMEOUT_CYC - 1)) begin
               timeout_flag <= 1'b1;
               o_disk_read  <= 1'b0;
               o_disk_write <= 1'b0;
               state        <= S_IDLE;
               tcnt         <= 32'd0;
            end else begin
               tcnt <= tcnt + 32'd1;
            end
         end else begin
            tcnt <= 32'd0;
         end
`endif

         // an emulator error aborts any command in flight
         if ((state != S_IDLE) && (i_sd_error != 4'd0)) begin
            sd_err       <= 1'b1;
            o_disk_read  <= 1'b0;
            o_disk_write <= 1'b0;
            state        <= S_IDLE;
         end
      end
   end

   always_comb begin
      status               = 8'h00;
      status[STAT_BUSY]    = o_busy;
      status[STAT_PARAM]   = param_err;
      status[STAT_SDERR]   = sd_err;
      status[STAT_TIMEOUT] = timeout_flag;
      status[STAT_READY]   = i_disk_ready;
      status[STAT_OVERRUN] = overrun;
   end

   always_comb begin
      o_io_data = 8'h00;
      case (i_io_addr)
         REG_DRIVE:  o_io_data = drive;
         REG_TRK_LO: o_io_data = trk_lo;
         REG_TRK_HI: o_io_data = trk_hi;
         REG_SECTOR: o_io_data = sector;
         REG_DMA_LO: o_io_data = dma_lo;
         REG_DMA_HI: o_io_data = dma_hi;
         REG_CMD:    o_io_data = cmd;
         REG_STATUS: o_io_data = status;
         default:    o_io_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_cpm_disk_ctrl.sv
// Scoreboard bench for cpm_disk_ctrl: randomized commands against an emulator model,
// expected completions queued by the stimulus and popped by a monitor on o_busy falling.
module tb_cpm_disk_ctrl;
   import cpm_disk_pkg::*;

   localparam int ND = 4, TR = 77, SP = 26, SB = 1, TO = 100;
   localparam int EMU_NORMAL = 0, EMU_SDERR = 1, EMU_STUCK = 2, EMU_HOLD = 3, EMU_LOW = 4;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic        i_io_wr;
   logic [2:0]  i_io_addr;
   logic [7:0]  i_io_data;
   logic [7:0]  o_io_data;
   logic        o_disk_read, o_disk_write;
   logic        i_disk_ready;
   logic [3:0]  i_sd_error;
   logic [23:0] o_disk_block_address;
   logic [1:0]  o_disk_block_sub_address;
   logic [15:0] o_dma_start_address;
   logic        o_busy;

   typedef struct {
      logic [7:0]  status;
      logic [23:0] blk;
      logic [1:0]  sub;
      logic [15:0] dma;
      bit          rd;
      bit          wr;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          emu_mode = EMU_NORMAL;
   logic [23:0] last_blk = '0;
   logic [1:0]  last_sub = '0;
   logic [15:0] last_dma = '0;

   always #5 clk = ~clk;

   cpm_disk_ctrl #(
      .NUM_DRIVES(ND), .TRACKS(TR), .SPT(SP), .SECTOR_BASE(SB), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk                    (clk),
      .i_reset_n                (i_reset_n),
      .i_io_wr                  (i_io_wr),
      .i_io_addr                (i_io_addr),
      .i_io_data                (i_io_data),
      .o_io_data                (o_io_data),
      .o_disk_read              (o_disk_read),
      .o_disk_write             (o_disk_write),
      .i_disk_ready             (i_disk_ready),
      .i_sd_error               (i_sd_error),
      .o_disk_block_address     (o_disk_block_address),
      .o_disk_block_sub_address (o_disk_block_sub_address),
      .o_dma_start_address      (o_dma_start_address),
      .o_busy                   (o_busy)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   // SD emulator: idle-high ready, drops ready some cycles after a request, later raises it
   initial begin : emu
      int phase, cnt;
      phase = 0; cnt = 0;
      i_disk_ready = 1'b1;
      i_sd_error   = 4'd0;
      forever begin
         @(posedge clk); #1;
         i_sd_error = 4'd0;
         if (emu_mode == EMU_LOW) begin
            i_disk_ready = 1'b0;
            phase = 0;
         end else begin
            case (phase)
               0: begin
                  i_disk_ready = 1'b1;
                  if (o_disk_read || o_disk_write) begin
                     phase = 1;
                     cnt = $urandom_range(3, 0);
                  end
               end
               1: if (emu_mode != EMU_HOLD) begin
                  if (cnt == 0) begin
                     i_disk_ready = 1'b0;
                     phase = 2;
                     cnt = $urandom_range(5, 1);
                  end else cnt--;
               end
               2: if (emu_mode == EMU_SDERR) begin
                  i_sd_error = 4'd4;
                  phase = 3;
                  cnt = 2;
               end else if (emu_mode != EMU_STUCK) begin
                  if (cnt == 0) begin
                     i_disk_ready = 1'b1;
                     phase = 0;
                  end else cnt--;
               end
               default: if (cnt == 0) begin
                  i_disk_ready = 1'b1;
                  phase = 0;
               end else cnt--;
            endcase
         end
      end
   end

   // monitor: on each command completion pop the expected record and compare
   initial begin : monitor
      bit   prev_busy, saw_rd, saw_wr, saw_both;
      exp_t e;
      prev_busy = 0; saw_rd = 0; saw_wr = 0; saw_both = 0;
      forever begin
         @(negedge clk);
         if (!i_reset_n) begin
            prev_busy = 0; saw_rd = 0; saw_wr = 0; saw_both = 0;
         end else begin
            if (o_disk_read) saw_rd = 1;
            if (o_disk_write) saw_wr = 1;
            if (o_disk_read && o_disk_write) saw_both = 1;
            if (prev_busy && !o_busy) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_completion", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("status", o_io_data, e.status | {3'b000, i_disk_ready, 4'b0000});
                  check("block_addr", o_disk_block_address, e.blk);
                  check("sub_addr", o_disk_block_sub_address, e.sub);
                  check("dma_addr", o_dma_start_address, e.dma);
                  check("read_req_seen", saw_rd, e.rd);
                  check("write_req_seen", saw_wr, e.wr);
                  check("req_both_high", saw_both, 0);
               end
               saw_rd = 0; saw_wr = 0; saw_both = 0;
            end
            prev_busy = o_busy;
         end
      end
   end

   task automatic io_write(input logic [2:0] a, input logic [7:0] d);
      i_io_addr = a; i_io_data = d; i_io_wr = 1'b1;
      @(posedge clk); #1;
      i_io_wr = 1'b0; i_io_addr = REG_STATUS;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input int drv, input int trk, input int sec, input logic [15:0] dma,
                          input bit wr, input bit ovr, input int mode);
      exp_t e;
      int   lba, n;
      bit   bad;
      emu_mode = mode;
      io_write(REG_DRIVE, 8'(drv));
      io_write(REG_TRK_LO, 8'(trk));
      io_write(REG_TRK_HI, 8'(trk >> 8));
      io_write(REG_SECTOR, 8'(sec));
      io_write(REG_DMA_LO, dma[7:0]);
      io_write(REG_DMA_HI, dma[15:8]);
      i_io_addr = REG_SECTOR; #1;
      check("sector_readback", o_io_data, 8'(sec));
      i_io_addr = REG_TRK_HI; #1;
      check("trk_hi_readback", o_io_data, 8'(trk >> 8));
      i_io_addr = REG_STATUS;
      bad = (drv >= ND) || (trk >= TR) || (sec < SB) || (sec >= SB + SP);
      lba = drv * TR * SP + trk * SP + (sec - SB);
      if (bad) begin
         e.status = 8'h02; e.blk = last_blk; e.sub = last_sub; e.dma = last_dma;
         e.rd = 0; e.wr = 0;
      end else begin
         e.blk = 24'(lba / 4); e.sub = 2'(lba % 4); e.dma = dma;
         e.rd = !wr; e.wr = wr;
         e.status = (mode == EMU_SDERR) ? 8'h04 : (mode == EMU_STUCK) ? 8'h08 : 8'h00;
         last_blk = e.blk; last_sub = e.sub; last_dma = dma;
      end
      if (ovr) e.status = e.status | 8'h80;
      exp_q.push_back(e);
      io_write(REG_CMD, wr ? CMD_WRITE : CMD_READ);
      if (ovr) io_write(REG_SECTOR, 8'(sec + 1));
      n = 0;
      while (o_busy && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_released", o_busy, 0);
      idle(1);
      i_io_addr = REG_CMD; #1;
      check("cmd_readback", o_io_data, wr ? CMD_WRITE : CMD_READ);
      i_io_addr = REG_STATUS;
      emu_mode = EMU_NORMAL;
      idle(2);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      i_reset_n = 1'b0; i_io_wr = 1'b0; i_io_addr = REG_STATUS; i_io_data = 8'h00;
      idle(3);
      check("rst_read_req", o_disk_read, 0);
      check("rst_write_req", o_disk_write, 0);
      check("rst_busy", o_busy, 0);
      check("rst_block", o_disk_block_address, 0);
      check("rst_dma", o_dma_start_address, 0);
      for (int r = 0; r < 8; r++) begin
         i_io_addr = 3'(r); #1;
         check("rst_reg", o_io_data, (r == 7) ? {3'b000, i_disk_ready, 4'b0000} : 8'h00);
      end
      i_io_addr = REG_STATUS;
      i_reset_n = 1'b1;
      idle(2);

      io_write(REG_STATUS, 8'hFF);
      #1;
      check("status_write_ignored", o_io_data, {3'b000, i_disk_ready, 4'b0000});

      run_cmd(0, 2, 1, 16'h1234, 0, 0, EMU_NORMAL);
      run_cmd(1, 0, 1, 16'h8000, 1, 0, EMU_NORMAL);
      run_cmd(0, 0, 27, 16'h0001, 0, 0, EMU_NORMAL);
      emu_mode = EMU_LOW; idle(2);
      run_cmd(4, 0, 1, 16'h0002, 1, 0, EMU_LOW);
      idle(2);
      run_cmd(3, 76, 26, 16'hBEEF, 0, 1, EMU_NORMAL);
      run_cmd(2, 10, 5, 16'h4321, 1, 0, EMU_SDERR);
      idle(8);

      // reset while the read request is held in the handshake
      emu_mode = EMU_HOLD;
      io_write(REG_DRIVE, 8'd0);
      io_write(REG_TRK_LO, 8'd2);
      io_write(REG_TRK_HI, 8'd0);
      io_write(REG_SECTOR, 8'd1);
      io_write(REG_CMD, CMD_READ);
      n = 0;
      while (!o_disk_read && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold_req_seen", o_disk_read, 1);
      i_reset_n = 1'b0; #1;
      check("rst_mid_issue_read", o_disk_read, 0);
      check("rst_mid_issue_write", o_disk_write, 0);
      check("rst_mid_issue_busy", o_busy, 0);
      idle(1);
      check("rst_mid_block", o_disk_block_address, 0);
      i_io_addr = REG_TRK_LO; #1;
      check("rst_mid_trk_lo", o_io_data, 0);
      i_io_addr = REG_STATUS;
      i_reset_n = 1'b1;
      emu_mode = EMU_NORMAL;
      last_blk = '0; last_sub = '0; last_dma = '0;
      idle(12);

`ifdef DISK_TIMEOUT_EN
      run_cmd(1, 5, 3, 16'h2222, 0, 0, EMU_STUCK);
      idle(12);
`endif

      for (int i = 0; i < 40; i++) begin
         int drv, trk, sec, mode;
         drv = ($urandom_range(9, 0) == 0) ? $urandom_range(255, 4) : $urandom_range(3, 0);
         case ($urandom_range(9, 0))
            0:       trk = $urandom_range(90, 77);
            1:       trk = $urandom_range(300, 256);
            default: trk = $urandom_range(76, 0);
         endcase
         case ($urandom_range(9, 0))
            0:       sec = 0;
            1:       sec = $urandom_range(40, 27);
            default: sec = $urandom_range(26, 1);
         endcase
         mode = ($urandom_range(7, 0) == 0) ? EMU_SDERR : EMU_NORMAL;
         run_cmd(drv, trk, sec, 16'($urandom), 1'($urandom_range(1, 0)),
                 ($urandom_range(5, 0) == 0), mode);
         if (mode == EMU_SDERR) idle(6);
      end

      idle(4);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpm_disk_ctrl.md
CPM_DISK_CTRL -- requirements
Module: cpm_disk_ctrl

Interface
REQ-001 SHALL have parameter NUM_DRIVES, default 4, number of logical drives.
REQ-002 SHALL have parameter TRACKS, default 77, tracks per drive.
REQ-003 SHALL have parameter SPT, default 26, 128-byte sectors per track.
REQ-004 SHALL have parameter SECTOR_BASE, default 1, number of the first CP/M sector.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 27_000_000, busy-timeout length in clocks.
REQ-006 i_clk  in  1  system clock.
REQ-007 i_reset_n  in  1  reset, asynchronous, active-low; one clock only.
REQ-008 i_io_wr  in  1  one-clock CPU port write strobe.
REQ-009 i_io_addr  in  3  register select.
REQ-010 i_io_data  in  8  CPU write data.
REQ-011 o_io_data  out  8  read data for the selected register, combinational.
REQ-012 o_disk_read / o_disk_write  out  1  level requests to the SD disk emulator.
REQ-013 i_disk_ready  in  1  emulator idle indication.
REQ-014 i_sd_error  in  4  emulator error code; 0 means no error.
REQ-015 o_disk_block_address  out  24  LBA[25:2].
REQ-016 o_disk_block_sub_address  out  2  LBA[1:0].
REQ-017 o_dma_start_address  out  16  DMA base address.
REQ-018 o_busy  out  1  command in progress.

Function
REQ-019 Register map: 0 drive; 1 track low; 2 track high; 3 sector; 4 DMA low; 5 DMA high; 6 command (write 8'h00 = read, 8'h01 = write); 7 status (read-only).
- Registers 0-5 SHALL read back their written value.
- Register 6 SHALL read back the last command.
REQ-020 Status bits:
- [0] busy
- [1] parameter error
- [2] SD error
- [3] timeout
- [4] i_disk_ready
- [7] overrun
- Others read 0.
REQ-021 FSM states SHALL be IDLE, CALC, ISSUE, BUSY, RELEASE.
REQ-022 A command write in IDLE SHALL clear status bits [3:1] and [7], then enter CALC.
REQ-023 CALC SHALL compute the 26-bit LBA = drive*TRACKS*SPT + track*SPT + (sector - SECTOR_BASE) in exactly 2 clocks, then latch the address outputs.
REQ-024 Parameter error handling:
- Applies if drive >= NUM_DRIVES, track >= TRACKS, sector < SECTOR_BASE, or sector >= SECTOR_BASE + SPT.
- Sets status[1] and returns to IDLE.
- No disk request is asserted.
REQ-025 ISSUE SHALL wait for i_disk_ready=1, assert the selected request, and hold it until i_disk_ready=0, then go to BUSY.
REQ-026 BUSY SHALL deassert both requests and go to RELEASE when i_disk_ready=1.
REQ-027 In any non-IDLE state, i_sd_error != 0 SHALL set status[2], drop the requests and return to IDLE.
REQ-028 RELEASE SHALL return to IDLE after one clock.
REQ-029 o_disk_read and o_disk_write SHALL never be high together.
REQ-030 o_busy SHALL be 1 in every state except IDLE.
REQ-031 Any port write while o_busy=1 SHALL be ignored and set status[7].
REQ-032 Port writes to register 7 SHALL be ignored.
REQ-033 Address outputs SHALL hold stable from CALC exit until the next command.

Reset
REQ-034 On i_reset_n=0:
- All registers, outputs and status are 0.
- FSM is IDLE.
- Requests are deasserted immediately, including mid-operation.

Configuration
REQ-035 With DISK_TIMEOUT_EN defined:
- A counter runs during ISSUE and BUSY.
- Reaching TIMEOUT_CYC sets status[3], drops the requests and returns to IDLE.
REQ-036 Without DISK_TIMEOUT_EN: no counter exists, and status[3] reads 0.

Structure
REQ-037 A shared package cpm_disk_pkg SHALL hold:
- register-index constants;
- command codes;
- status bit positions;
- the FSM state enum.
REQ-038 The LBA computation SHALL be sub-module cpm_lba_calc:
- 2-stage pipelined;
- inputs drive, track, sector and the parameters;
- outputs lba and invalid.

Verification
REQ-039 Drive 0, track 2, sector 1, read command -> block 13, sub 0; o_disk_read pulses through the handshake; o_busy low after i_disk_ready returns to 1.
REQ-040 Drive 1, track 0, sector 1, write command -> LBA 2002: block 500, sub 2; o_disk_write only.
REQ-041 Sector 27 (SPT=26) or drive 4 -> status = 8'h02 (i_disk_ready=0) or 8'h12 (i_disk_ready=1); no request asserted.
REQ-042 Command written while busy -> status[7]=1; in-flight addresses unchanged.
REQ-043 i_sd_error=4 during BUSY -> status[2]=1, FSM IDLE; i_reset_n pulse mid-ISSUE -> requests 0 in the same cycle.
REQ-044 DISK_TIMEOUT_EN with TIMEOUT_CYC=100 and i_disk_ready stuck at 0 after issue -> status[3]=1 after 100 clocks.
